// File: rtl/dense_stream_mac.sv
// dense_stream_mac: time-multiplexed fully-connected layer with valid/ready streaming
module dense_stream_mac #(
  parameter int N_IN = 64,
  parameter int N_OUT = 16,
  parameter int PAR = 16,
  parameter int DW = 8,
  parameter int FRAC = 5,
  parameter int ACC_W = 2 * DW + $clog2(N_IN) + 1,
  parameter int RELU = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_IN*DW-1:0] in_data,
  input  logic [N_IN*N_OUT*DW-1:0] weights,
  input  logic [N_OUT*DW-1:0] biases,
  output logic out_valid,
  input  logic out_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic busy
);
  localparam int BEATS = N_IN / PAR;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, FINAL, OUT} state_t;
  state_t state, state_nxt;
  logic [BW-1:0] beat;
  logic last, accept, psum_v;
  logic [N_IN*DW-1:0] x_r;
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [ACC_W-1:0] psum [N_OUT];
  logic signed [ACC_W-1:0] psum_c [N_OUT];
  logic signed [2*DW-1:0] prod;
  logic signed [ACC_W-1:0] sh;
  logic [DW-1:0] sat;
  logic [N_OUT*DW-1:0] res;
  assign in_ready = !rst && (state == IDLE || (state == OUT && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == OUT;
  assign busy = state == MAC || state == DRAIN || state == FINAL;
  assign last = beat == BW'(BEATS - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (accept ? MAC : IDLE) :
                state == MAC   ? (last ? DRAIN : MAC) :
                state == DRAIN ? FINAL :
                state == FINAL ? OUT :
                accept ? MAC : out_ready ? IDLE : OUT;
  end
  always_comb begin
    prod = '0;
    for (int o = 0; o < N_OUT; o++) begin
      psum_c[o] = '0;
      for (int c = 0; c < PAR; c++) begin
        prod = $signed(x_r[DW*(int'(beat)*PAR+c) +: DW]) *
               $signed(weights[DW*((int'(beat)*PAR+c)*N_OUT+o) +: DW]);
        psum_c[o] = psum_c[o] + ACC_W'(prod);
      end
    end
  end
  always_comb begin
    sh = '0;
    sat = '0;
    res = '0;
    for (int o = 0; o < N_OUT; o++) begin
      sh = acc[o] >>> FRAC;
      sat = sh > SMAX ? SMAX[DW-1:0] : sh < SMIN ? SMIN[DW-1:0] : sh[DW-1:0];
      res[DW*o +: DW] = (RELU != 0 && sat[DW-1]) ? '0 : sat;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      psum_v <= 1'b0;
      x_r <= '0;
      out_data <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        acc[o] <= '0;
        psum[o] <= '0;
      end
    end else begin
      state <= state_nxt;
      psum_v <= state == MAC;
      beat <= accept ? '0 : (state == MAC && !last) ? beat + 1'b1 : beat;
      if (accept) x_r <= in_data;
      if (state == FINAL) out_data <= res;
      for (int o = 0; o < N_OUT; o++) begin
        if (state == MAC) psum[o] <= psum_c[o];
        acc[o] <= accept ? ACC_W'($signed(biases[DW*o +: DW])) <<< FRAC :
                  psum_v ? acc[o] + psum[o] : acc[o];
      end
    end
  end
endmodule

// File: tb/tb_dense_stream_mac.sv
// tb_dense_stream_mac: scoreboard bench for two dense_stream_mac configurations
module tb_dense_stream_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] in_data;
  logic [8191:0] weights;
  logic [127:0] biases;
  logic in_valid [2];
  logic in_ready [2];
  logic out_valid [2];
  logic out_ready [2];
  logic busy [2];
  logic [127:0] out_data [2];
  int x [64];
  int w [64][16];
  int b [16];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q [2][$];
  int acc_t [2][$];
  int last_acc [2];
  logic prev_ov [2];
  logic prev_rdy [2];
  logic [127:0] prev_od [2];
  bit rnd_rdy = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dense_stream_mac u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .weights(weights), .biases(biases),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );
  dense_stream_mac #(.PAR(64), .RELU(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .weights(weights), .biases(biases),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );
  task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, expv);
    end
  endtask
  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction
  function automatic logic [127:0] model(bit relu);
    logic [127:0] r;
    int s;
    r = '0;
    for (int o = 0; o < 16; o++) begin
      s = b[o] * 32;
      for (int i = 0; i < 64; i++) s += x[i] * w[i][o];
      s = s >>> 5;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      r[8*o +: 8] = 8'(s);
    end
    return r;
  endfunction
  task automatic fill(int xv, int wv, int bv, bit rnd);
    for (int i = 0; i < 64; i++) begin
      x[i] = rnd ? rnd8() : xv;
      for (int o = 0; o < 16; o++) w[i][o] = rnd ? rnd8() : wv;
    end
    for (int o = 0; o < 16; o++) b[o] = rnd ? rnd8() : bv;
  endtask
  task automatic pack();
    for (int i = 0; i < 64; i++) begin
      in_data[8*i +: 8] = 8'(x[i]);
      for (int o = 0; o < 16; o++) weights[8*(i*16+o) +: 8] = 8'(w[i][o]);
    end
    for (int o = 0; o < 16; o++) biases[8*o +: 8] = 8'(b[o]);
  endtask
  task automatic send(int k, bit push, bit tp);
    int n = 0;
    @(negedge clk);
    while (busy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    pack();
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d got in_ready=0 expected 1", k);
      in_valid[k] = 1'b0;
      return;
    end
    if (push) exp_q[k].push_back(model(k == 0));
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    if (tp) chk($sformatf("throughput%0d", k), cyc - last_acc[k], k == 0 ? 7 : 4);
    last_acc[k] = cyc;
    if (push) acc_t[k].push_back(cyc);
  endtask
  task automatic wait_drain(int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[k].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d got %0d pending expected 0", k, exp_q[k].size());
      exp_q[k].delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic mon(int k);
    if (rst) begin
      prev_ov[k] = 1'b0;
      prev_rdy[k] = 1'b0;
      return;
    end
    if (prev_ov[k] && !prev_rdy[k]) begin
      chk($sformatf("hold_valid%0d", k), out_valid[k], 1);
      chk($sformatf("hold_data%0d", k), out_data[k], prev_od[k]);
    end
    if (out_valid[k] && !prev_ov[k]) begin
      checks++;
      if (acc_t[k].size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid dut%0d got out_valid=1 expected 0", k);
      end else begin
        checks--;
        chk($sformatf("latency%0d", k), cyc - acc_t[k].pop_front(), k == 0 ? 6 : 3);
      end
    end
    if (out_valid[k] && out_ready[k]) begin
      checks++;
      if (exp_q[k].size() == 0) begin
        errors++;
        $display("FAIL unexpected_output dut%0d got %h expected none", k, out_data[k]);
      end else begin
        checks--;
        chk($sformatf("result%0d", k), out_data[k], exp_q[k].pop_front());
      end
    end
    prev_ov[k] = out_valid[k];
    prev_rdy[k] = out_ready[k];
    prev_od[k] = out_data[k];
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_rdy) out_ready[0] = 1'($urandom_range(1));
  end
  initial begin
    logic bad;
    int n;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    fill(0, 0, 0, 1'b0);
    pack();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_out_data", out_data[k], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready0", in_ready[0], 1);
    chk("post_rst_in_ready1", in_ready[1], 1);
    fill(0, 0, 0, 1'b1);
    for (int i = 0; i < 64; i++) x[i] = 0;
    b[0] = -7;
    b[1] = 9;
    send(0, 1'b1, 1'b0);
    fill(32, 1, 0, 1'b0);
    send(0, 1'b1, 1'b0);
    fill(127, 127, 0, 1'b0);
    send(0, 1'b1, 1'b0);
    wait_drain(0);
    fill(127, -127, 0, 1'b0);
    send(1, 1'b1, 1'b0);
    fill(0, 0, 0, 1'b0);
    x[0] = 1;
    w[0][0] = -1;
    send(1, 1'b1, 1'b0);
    wait_drain(1);
    out_ready[0] = 1'b0;
    fill(0, 0, 0, 1'b1);
    send(0, 1'b1, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad |= in_ready[0];
    end
    chk("bp_in_ready", bad, 0);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    fill(0, 0, 0, 1'b1);
    send(0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_valid_drop", out_valid[0], 0);
    wait_drain(0);
    fill(0, 0, 0, 1'b1);
    send(0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", in_ready[0], 1);
    chk("midrst_busy_after", busy[0], 0);
    bad = out_valid[0];
    repeat (8) begin
      @(negedge clk);
      bad |= out_valid[0];
    end
    chk("midrst_no_output", bad, 0);
    fill(0, 0, 0, 1'b1);
    send(0, 1'b1, 1'b0);
    wait_drain(0);
    rnd_rdy = 1'b1;
    repeat (12) begin
      fill(0, 0, 0, 1'b1);
      send(0, 1'b1, 1'b0);
    end
    wait_drain(0);
    rnd_rdy = 1'b0;
    out_ready[0] = 1'b1;
    fill(0, 0, 0, 1'b1);
    send(0, 1'b1, 1'b0);
    repeat (3) begin
      fill(0, 0, 0, 1'b1);
      send(0, 1'b1, 1'b1);
    end
    wait_drain(0);
    fill(0, 0, 0, 1'b1);
    send(1, 1'b1, 1'b0);
    repeat (8) begin
      fill(0, 0, 0, 1'b1);
      send(1, 1'b1, 1'b1);
    end
    wait_drain(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_stream_mac.md
# dense_stream_mac

Parametrised, time-multiplexed fully-connected layer: `out[o] = act(bias[o] + Σ_i w[i][o]·x[i])` over `N_IN` signed fixed-point inputs and `N_OUT` outputs. It processes `PAR` input columns per cycle and accumulates at full precision. Rounding and saturation happen once, at the end. It sits between layer blocks in the inference pipeline, with valid/ready handshakes on both sides and back-pressure support.

## Interface
- `N_IN`, 64: input vector length; must be divisible by `PAR`.
- `N_OUT`, 16: output vector length.
- `PAR`, 16: input columns processed per cycle. `BEATS = N_IN/PAR`.
- `DW`, 8: data, weight and bias width, signed two's complement.
- `FRAC`, 5: fractional bits shared by data, weights, biases and outputs.
- `ACC_W`, `2*DW+$clog2(N_IN)+1`: accumulator width.
- `RELU`, 1: 1 = ReLU on outputs; 0 = identity.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block accepts input this cycle.
- `in_data` input `N_IN*DW`: element i at bits `[DW*i +: DW]`.
- `weights` input `N_IN*N_OUT*DW`: w[i][o] at `[DW*(i*N_OUT+o) +: DW]`. Static while busy.
- `biases` input `N_OUT*DW`: bias[o] at `[DW*o +: DW]`. Static while busy.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: downstream accepts output.
- `out_data` output `N_OUT*DW`: result o at `[DW*o +: DW]`.
- `busy` output 1: high in MAC, DRAIN and FINAL.

## Operation
- **States:** IDLE, MAC, DRAIN, FINAL, OUT.
- **Input acceptance:** input is accepted when `in_valid && in_ready`.
  - `in_ready = !rst && (IDLE || (OUT && out_ready))`.
  - On acceptance, `in_data` is captured into an internal register. Later changes to `in_data` are ignored.
  - Each `acc[o]` is loaded with `sign_ext(bias[o]) << FRAC`.
  - The beat counter is cleared and the state moves to MAC.
- **MAC** lasts `BEATS` cycles; the beat counter is b.
  - Stage A registers `psum[o] = Σ_{c<PAR} x[b*PAR+c]·w[b*PAR+c][o]`, using full 2·DW-bit products, sign-extended to `ACC_W`.
  - Stage B performs `acc[o] += psum[o]` on the cycle after each stage-A valid.
  - When b = `BEATS-1`, the state moves to DRAIN.
- **DRAIN** lasts 1 cycle: the last psum is accumulated. The state then moves to FINAL.
- **FINAL** lasts 1 cycle and registers `out_data[o] = act(sat(acc[o] >>> FRAC))`.
  - `>>>` is an arithmetic shift, i.e. floor rounding.
  - `sat` clamps to `[-2^(DW-1), 2^(DW-1)-1]`.
  - `act` is `max(0, ·)` when `RELU` = 1.
  - The state then moves to OUT.
- **OUT:** `out_valid` = 1 and `out_data` is held stable until `out_ready`.
  - On `out_ready` with a simultaneous input acceptance: the state moves to MAC, the new input is captured, and the accumulators are reloaded with the biases.
  - On `out_ready` without input: the state moves to IDLE.
- **No intermediate wrap:** `ACC_W` is sized so that no intermediate overflow occurs for any input.

## Timing
- **Reset values:**
  - State IDLE, `out_valid` 0, `out_data` 0, `busy` 0.
  - Accumulators, pipeline registers and beat counter all 0.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` falls.
- **Latency:** `out_valid` rises `BEATS+2` clock edges after the accepting edge. N_IN=64, PAR=16 gives 6 edges; PAR=N_IN gives 3 edges.
- **Throughput:** one vector per `BEATS+3` cycles when `out_ready` is held high and `in_valid` is held high.
- **No overlap:** inputs are not accepted during MAC, DRAIN or FINAL, and `in_ready` is 0 throughout.
- **Reset mid-operation:** `rst` in any state aborts the in-flight vector with no output produced. The post-reset behaviour is identical to power-up reset.
- **Output stability:** `out_valid` never drops without `out_ready`, and `out_data` is constant while `out_valid && !out_ready`.

## Test plan
- **Bias pass-through:** defaults, `in_data` = 0, biases {0xF9, 0x09, …} → `out_data[0]` = 0x00 (ReLU), `out_data[1]` = 0x09. `out_valid` asserts 6 edges after acceptance.
- **Accumulation:** all x = 0x20 (1.0), all w = 0x01, biases 0 → sum 64·32 = 2048, >>5 = 64, so every output is 0x40.
- **Saturation:** all x = 0x7F, w = 0x7F → 0x7F. With `RELU` = 0 and w = 0x81 → 0x80. No wrap is allowed.
- **Floor rounding:** `RELU` = 0, PAR = N_IN. Only x[0] = 0x01, w[0][0] = 0xFF, bias 0 → product −1, result 0xFF. `out_valid` asserts 3 edges after acceptance.
- **Back-pressure:** hold `out_ready` = 0 for 10 cycles → `out_data` is stable and `in_ready` = 0. Then raise `out_ready` and `in_valid` together → the new vector is accepted, `out_valid` is 0 on the next cycle, and the second result is correct 6 edges later.
- **Reset mid-operation:** pulse `rst` at beat 2 of MAC → `out_valid` stays 0, `in_ready` = 1 after reset, and the next vector gives the correct result with normal latency.
